// File: rtl/handshake_pkg.sv
// Shared constants and types for the handshake responder: legal parameter
// ranges and the data strobe state encoding.
package handshake_pkg;

  localparam int ACK_DELAY_MIN   = 2;
  localparam int ACK_DELAY_MAX   = 8;
  localparam int DATA_PERIOD_MIN = 3;
  localparam int DATA_PERIOD_MAX = 6;

  // Wide enough to hold DATA_PERIOD_MAX-1
  localparam int PCNT_W = $clog2(DATA_PERIOD_MAX);

  typedef enum logic {STROBE_IDLE, STROBE_RUN} strobe_state_t;

endpackage

// File: rtl/handshake_responder_rise_delay_line.sv
// Fixed-depth shift register carrying rise events toward the ack logic;
// synchronous clear drops every event still in flight.
module rise_delay_line #(
  parameter int DEPTH = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic dout
);

  logic [DEPTH-1:0] stages;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      stages <= '0;
    end else begin
      stages[0] <= din;
      for (int i = 1; i < DEPTH; i++) stages[i] <= stages[i-1];
    end
  end

  assign dout = stages[DEPTH-1];

endmodule

// File: rtl/handshake_responder.sv
// Drives ack/enable a fixed delay after each req rise and a free-running
// data strobe that starts on the first acknowledged request.
module handshake_responder
  import handshake_pkg::*;
#(
  parameter int ACK_DELAY   = 2,
  parameter int DATA_PERIOD = 4,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req,
  output logic             ack,
  output logic             enable,
  output logic             data,
  output logic             strobe_active,
  output logic [CNT_W-1:0] ack_count
);

  if (ACK_DELAY < ACK_DELAY_MIN || ACK_DELAY > ACK_DELAY_MAX) begin : g_bad_ack_delay
    $error("handshake_responder: ACK_DELAY %0d out of range", ACK_DELAY);
  end
  if (DATA_PERIOD < DATA_PERIOD_MIN || DATA_PERIOD > DATA_PERIOD_MAX) begin : g_bad_data_period
    $error("handshake_responder: DATA_PERIOD %0d out of range", DATA_PERIOD);
  end

  localparam logic [PCNT_W-1:0] PCNT_LOAD = PCNT_W'(DATA_PERIOD - 1);

  logic              req_q;
  logic              rise;
  logic              fire;
  logic              ack_nxt;
  strobe_state_t     state;
  logic [PCNT_W-1:0] period_cnt;

  // req_q resets high so a req already asserted at reset release is not a rise
  always_ff @(posedge clk) begin
    if (!rst_n) req_q <= 1'b1;
    else        req_q <= req;
  end

  assign rise = req & ~req_q;

  rise_delay_line #(.DEPTH(ACK_DELAY - 1)) u_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   (rise),
    .dout  (fire)
  );

  // fire dominates a simultaneous req fall
  assign ack_nxt = fire | (ack & req);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ack       <= 1'b0;
      enable    <= 1'b0;
      ack_count <= '0;
    end else begin
      ack    <= ack_nxt;
      enable <= ack_nxt;
      if (fire && ack_count != {CNT_W{1'b1}}) ack_count <= ack_count + CNT_W'(1);
    end
  end

  // Strobe is phased by the first fire only; later fires never re-phase it
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state         <= STROBE_IDLE;
      data          <= 1'b0;
      strobe_active <= 1'b0;
      period_cnt    <= '0;
    end else begin
      case (state)
        STROBE_IDLE: begin
          if (fire) begin
            state         <= STROBE_RUN;
            data          <= ~data;
            strobe_active <= 1'b1;
            period_cnt    <= PCNT_LOAD;
          end
        end
        STROBE_RUN: begin
          if (period_cnt == '0) begin
            data       <= ~data;
            period_cnt <= PCNT_LOAD;
          end else begin
            period_cnt <= period_cnt - PCNT_W'(1);
          end
        end
        default: state <= STROBE_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_handshake_responder.sv
// Directed bench for handshake_responder: three parameterisations share the
// clock and reset; each task drives one scenario and checks it inline.
module tb_handshake_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n = 1'b0;
  logic       req2 = 1'b0, req4 = 1'b0, reqc = 1'b0;
  logic       ack2, en2, data2, sa2;
  logic [7:0] cnt2;
  logic       ack4, en4, data4, sa4;
  logic [7:0] cnt4;
  logic       ackc, enc, datac, sac;
  logic [1:0] cntc;

  int checks   = 0;
  int failures = 0;

  handshake_responder u_d2 (
    .clk(clk), .rst_n(rst_n), .req(req2), .ack(ack2), .enable(en2),
    .data(data2), .strobe_active(sa2), .ack_count(cnt2)
  );

  handshake_responder #(.ACK_DELAY(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .req(req4), .ack(ack4), .enable(en4),
    .data(data4), .strobe_active(sa4), .ack_count(cnt4)
  );

  handshake_responder #(.CNT_W(2)) u_c2 (
    .clk(clk), .rst_n(rst_n), .req(reqc), .ack(ackc), .enable(enc),
    .data(datac), .strobe_active(sac), .ack_count(cntc)
  );

  // Value observed after edge e is what a checker samples at edge e+1
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Afterwards, edge 0 is the first edge with rst_n sampled high
  task automatic do_reset();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
    step();
  endtask

  task automatic test_reset();
    req2 = 1'b1; req4 = 1'b1; reqc = 1'b1;
    do_reset();
    for (int e = 1; e <= 15; e++) begin
      step();
      checks++;
      if (ack2 !== 1'b0 || en2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_ack2 e=%0d got=%b/%b exp=0/0", e, ack2, en2);
      end
      checks++;
      if (ack4 !== 1'b0 || ackc !== 1'b0) begin
        failures++;
        $display("FAIL reset_ack_other e=%0d got=%b/%b exp=0/0", e, ack4, ackc);
      end
      checks++;
      if (data2 !== 1'b0 || sa2 !== 1'b0) begin
        failures++;
        $display("FAIL reset_data e=%0d got=%b/%b exp=0/0", e, data2, sa2);
      end
    end
    checks++;
    if (cnt2 !== 8'd0) begin
      failures++;
      $display("FAIL reset_count got=%0d exp=0", cnt2);
    end
  endtask

  // req sampled high at edges 10..19; ack registered 11..19, data toggles every 4
  task automatic test_hold();
    logic exp_a, exp_d;
    req2 = 1'b0;
    do_reset();
    for (int e = 1; e <= 30; e++) begin
      req2 = (e >= 10 && e <= 19);
      step();
      exp_a = (e >= 11 && e <= 19);
      exp_d = (e >= 11) ? (((e - 11) / 4) % 2 == 0) : 1'b0;
      checks++;
      if (ack2 !== exp_a || en2 !== exp_a) begin
        failures++;
        $display("FAIL hold_ack e=%0d got=%b/%b exp=%b", e, ack2, en2, exp_a);
      end
      checks++;
      if (data2 !== exp_d) begin
        failures++;
        $display("FAIL hold_data e=%0d got=%b exp=%b", e, data2, exp_d);
      end
      checks++;
      if (sa2 !== (e >= 11)) begin
        failures++;
        $display("FAIL hold_active e=%0d got=%b exp=%b", e, sa2, (e >= 11));
      end
    end
    checks++;
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL hold_count got=%0d exp=1", cnt2);
    end
  endtask

  task automatic test_pulse();
    logic exp_a;
    req2 = 1'b0;
    do_reset();
    for (int e = 1; e <= 20; e++) begin
      req2 = (e == 10);
      step();
      exp_a = (e == 11);
      checks++;
      if (ack2 !== exp_a || en2 !== exp_a) begin
        failures++;
        $display("FAIL pulse_ack e=%0d got=%b/%b exp=%b", e, ack2, en2, exp_a);
      end
    end
    checks++;
    if (cnt2 !== 8'd1) begin
      failures++;
      $display("FAIL pulse_count got=%0d exp=1", cnt2);
    end
  endtask

  // ACK_DELAY=4, pulses at edges 10/12/14: fires at 13/15/17, and the pulse
  // at 14 holds ack through edge 14
  task automatic test_back_to_back();
    logic exp_a;
    req4 = 1'b0;
    do_reset();
    for (int e = 1; e <= 24; e++) begin
      req4 = (e == 10 || e == 12 || e == 14);
      step();
      exp_a = (e == 13 || e == 14 || e == 15 || e == 17);
      checks++;
      if (ack4 !== exp_a || en4 !== exp_a) begin
        failures++;
        $display("FAIL b2b_ack e=%0d got=%b/%b exp=%b", e, ack4, en4, exp_a);
      end
    end
    checks++;
    if (cnt4 !== 8'd3) begin
      failures++;
      $display("FAIL b2b_count got=%0d exp=3", cnt4);
    end
  endtask

  task automatic test_reset_mid();
    req2 = 1'b0;
    do_reset();
    for (int e = 1; e <= 25; e++) begin
      req2  = (e >= 10);
      rst_n = (e != 11);
      step();
      if (e >= 11) begin
        checks++;
        if (ack2 !== 1'b0 || en2 !== 1'b0) begin
          failures++;
          $display("FAIL mid_reset_ack e=%0d got=%b/%b exp=0/0", e, ack2, en2);
        end
        checks++;
        if (cnt2 !== 8'd0 || sa2 !== 1'b0) begin
          failures++;
          $display("FAIL mid_reset_state e=%0d cnt=%0d active=%b exp=0/0", e, cnt2, sa2);
        end
      end
    end
    rst_n = 1'b1;
  endtask

  task automatic test_saturate();
    reqc = 1'b0;
    do_reset();
    for (int e = 1; e <= 40; e++) begin
      reqc = (e == 10 || e == 14 || e == 18 || e == 22 || e == 26);
      step();
      if (e == 16) begin
        checks++;
        if (cntc !== 2'd2) begin
          failures++;
          $display("FAIL sat_mid_count got=%0d exp=2", cntc);
        end
      end
    end
    checks++;
    if (cntc !== 2'd3) begin
      failures++;
      $display("FAIL sat_count got=%0d exp=3", cntc);
    end
  endtask

  task automatic test_random();
    logic r, prev_req, rise_prev, fire, rise, m_ack, m_data;
    int   m_cnt, first;
    req2 = 1'b0;
    do_reset();
    prev_req = 1'b0; rise_prev = 1'b0; m_ack = 1'b0; m_cnt = 0; first = -1;
    for (int e = 1; e <= 300; e++) begin
      r    = 1'($urandom_range(0, 1));
      req2 = r;
      step();
      fire  = rise_prev;
      rise  = r & ~prev_req;
      m_ack = fire | (m_ack & r);
      if (fire) m_cnt++;
      if (fire && first < 0) first = e;
      m_data = (first < 0) ? 1'b0 : (((e - first) / 4) % 2 == 0);
      prev_req  = r;
      rise_prev = rise;
      checks++;
      if (ack2 !== m_ack || en2 !== m_ack) begin
        failures++;
        $display("FAIL rand_ack e=%0d got=%b/%b exp=%b", e, ack2, en2, m_ack);
      end
      checks++;
      if (data2 !== m_data) begin
        failures++;
        $display("FAIL rand_data e=%0d got=%b exp=%b", e, data2, m_data);
      end
      checks++;
      if (cnt2 !== 8'(m_cnt)) begin
        failures++;
        $display("FAIL rand_count e=%0d got=%0d exp=%0d", e, cnt2, m_cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold();
    test_pulse();
    test_back_to_back();
    test_reset_mid();
    test_saturate();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
